// File: rtl/mem_stage.sv
// Memory-access stage: takes one instruction from EX, runs a valid/ready data-memory
// transaction for aligned loads/stores and emits a registered one-cycle writeback packet.
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [63:0] ex_alu_res,
    input  logic [63:0] ex_store_data,
    input  logic        ex_mem_rd,
    input  logic        ex_mem_wr,
    input  logic [2:0]  ex_mem_op,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_wen,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [63:0] dmem_addr,
    output logic        dmem_we,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [63:0] dmem_rdata,
    output logic        wb_valid,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_wen,
    output logic        misalign
);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  off_q, off_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic        wen_q, wen_d;
    logic        ld_q, ld_d;

    logic        req_valid_q, req_valid_d;
    logic [63:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;

    logic        wb_valid_q, wb_valid_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_wen_q, wb_wen_d;
    logic        misalign_q, misalign_d;

    logic [1:0]  ex_size;
    logic [2:0]  ex_off;
    logic        ex_mis;
    logic [7:0]  st_strb;
    logic [63:0] st_data;
    logic [63:0] lane;
    logic [63:0] ld_val;

    // Undefined store ops act as SD, undefined load op 111 acts as LD.
    always_comb begin
        ex_off = ex_alu_res[2:0];
        if (ex_mem_wr) begin
            ex_size = ex_mem_op[2] ? 2'd3 : ex_mem_op[1:0];
        end else begin
            ex_size = (ex_mem_op == 3'b111) ? 2'd3 : ex_mem_op[1:0];
        end
        case (ex_size)
            2'd1:    ex_mis = ex_off[0];
            2'd2:    ex_mis = |ex_off[1:0];
            2'd3:    ex_mis = |ex_off;
            default: ex_mis = 1'b0;
        endcase
        case (ex_size)
            2'd0: begin
                st_strb = 8'h01 << ex_off;
                st_data = {8{ex_store_data[7:0]}};
            end
            2'd1: begin
                st_strb = 8'h03 << ex_off;
                st_data = {4{ex_store_data[15:0]}};
            end
            2'd2: begin
                st_strb = 8'h0F << ex_off;
                st_data = {2{ex_store_data[31:0]}};
            end
            default: begin
                st_strb = 8'hFF;
                st_data = ex_store_data;
            end
        endcase
    end

    always_comb begin
        lane = dmem_rdata >> {off_q, 3'b000};
        case (op_q)
            3'b000:  ld_val = {{56{lane[7]}}, lane[7:0]};
            3'b001:  ld_val = {{48{lane[15]}}, lane[15:0]};
            3'b010:  ld_val = {{32{lane[31]}}, lane[31:0]};
            3'b100:  ld_val = {56'd0, lane[7:0]};
            3'b101:  ld_val = {48'd0, lane[15:0]};
            3'b110:  ld_val = {32'd0, lane[31:0]};
            default: ld_val = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        op_d        = op_q;
        rd_d        = rd_q;
        wen_d       = wen_q;
        ld_d        = ld_q;
        req_valid_d = req_valid_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_wen_d    = wb_wen_q;
        misalign_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    off_d = ex_off;
                    op_d  = ex_mem_op;
                    rd_d  = ex_rd;
                    wen_d = ex_reg_wen;
                    ld_d  = ex_mem_rd;
                    if (!ex_mem_rd && !ex_mem_wr) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_res;
                        wb_rd_d    = ex_rd;
                        wb_wen_d   = ex_reg_wen;
                    end else if (ex_mis) begin
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b1;
                        wb_data_d  = 64'd0;
                        wb_rd_d    = ex_rd;
                        wb_wen_d   = 1'b0;
                    end else begin
                        state_d     = StReq;
                        req_valid_d = 1'b1;
                        addr_d      = ex_alu_res;
                        we_d        = ex_mem_wr;
                        wdata_d     = ex_mem_wr ? st_data : 64'd0;
                        wstrb_d     = ex_mem_wr ? st_strb : 8'd0;
                    end
                end
            end
            StReq: begin
                if (dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    addr_d      = 64'd0;
                    we_d        = 1'b0;
                    wdata_d     = 64'd0;
                    wstrb_d     = 8'd0;
                    if (ld_q) begin
                        state_d = StRsp;
                    end else begin
                        state_d    = StIdle;
                        wb_valid_d = 1'b1;
                        wb_data_d  = 64'd0;
                        wb_rd_d    = rd_q;
                        wb_wen_d   = 1'b0;
                    end
                end
            end
            StRsp: begin
                if (dmem_rsp_valid) begin
                    state_d    = StIdle;
                    wb_valid_d = 1'b1;
                    wb_data_d  = ld_val;
                    wb_rd_d    = rd_q;
                    wb_wen_d   = wen_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            off_q       <= 3'd0;
            op_q        <= 3'd0;
            rd_q        <= 5'd0;
            wen_q       <= 1'b0;
            ld_q        <= 1'b0;
            req_valid_q <= 1'b0;
            addr_q      <= 64'd0;
            we_q        <= 1'b0;
            wdata_q     <= 64'd0;
            wstrb_q     <= 8'd0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= 64'd0;
            wb_rd_q     <= 5'd0;
            wb_wen_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            wen_q       <= wen_d;
            ld_q        <= ld_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_wen_q    <= wb_wen_d;
            misalign_q  <= misalign_d;
        end
    end

    assign ex_ready       = (state_q == StIdle);
    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = addr_q;
    assign dmem_we        = we_q;
    assign dmem_wdata     = wdata_q;
    assign dmem_wstrb     = wstrb_q;
    assign wb_valid       = wb_valid_q;
    assign wb_data        = wb_data_q;
    assign wb_rd          = wb_rd_q;
    assign wb_wen         = wb_wen_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of instruction vectors with a writeback scoreboard,
// plus a hand-written reset-during-response sequence.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [63:0] ex_alu_res = '0;
    logic [63:0] ex_store_data = '0;
    logic        ex_mem_rd = 1'b0;
    logic        ex_mem_wr = 1'b0;
    logic [2:0]  ex_mem_op = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_reg_wen = 1'b0;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic [63:0] dmem_addr;
    logic        dmem_we;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_rsp_valid = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic        misalign;

    mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_res     (ex_alu_res),
        .ex_store_data  (ex_store_data),
        .ex_mem_rd      (ex_mem_rd),
        .ex_mem_wr      (ex_mem_wr),
        .ex_mem_op      (ex_mem_op),
        .ex_rd          (ex_rd),
        .ex_reg_wen     (ex_reg_wen),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .wb_valid       (wb_valid),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_wen         (wb_wen),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] sdata;
        logic        ld;
        logic        st;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        wen;
        int          rq;
        int          rs;
        logic [63:0] rdata;
        logic [63:0] exp_data;
        logic        mis;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
        int          due;
    } pkt_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    pkt_t sb[$];
    pkt_t mon_p;
    vec_t vecs[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each writeback must match the head entry and arrive on its due cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 64'(wb_valid), 64'd0);
            end else begin
                mon_p = sb.pop_front();
                chk("wb_cycle", 64'(cyc), 64'(mon_p.due));
                chk("wb_data", wb_data, mon_p.data);
                chk("wb_rd", 64'(wb_rd), 64'(mon_p.rd));
                chk("wb_wen", 64'(wb_wen), 64'(mon_p.wen));
                chk("wb_misalign", 64'(misalign), 64'(mon_p.mis));
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("wb_missing", 64'(wb_valid), 64'd1);
            void'(sb.pop_front());
        end
    end

    function automatic vec_t mk(input logic [63:0] alu, input logic [63:0] sdata,
                                input logic ld, input logic st, input logic [2:0] op,
                                input logic [4:0] rd, input logic wen, input int rq,
                                input int rs, input logic [63:0] rdata,
                                input logic [63:0] exp_data, input logic mis,
                                input logic [7:0] strb, input logic [63:0] wdata);
        vec_t v;
        v.alu = alu; v.sdata = sdata; v.ld = ld; v.st = st; v.op = op; v.rd = rd;
        v.wen = wen; v.rq = rq; v.rs = rs; v.rdata = rdata; v.exp_data = exp_data;
        v.mis = mis; v.strb = strb; v.wdata = wdata;
        return v;
    endfunction

    // Called at 1 time unit after a rising edge; returns at the same phase.
    task automatic run(input vec_t v);
        pkt_t p;
        bit   mem;
        mem = v.ld | v.st;
        chk("ex_ready", 64'(ex_ready), 64'd1);
        ex_valid      = 1'b1;
        ex_alu_res    = v.alu;
        ex_store_data = v.sdata;
        ex_mem_rd     = v.ld;
        ex_mem_wr     = v.st;
        ex_mem_op     = v.op;
        ex_rd         = v.rd;
        ex_reg_wen    = v.wen;
        p.data = v.exp_data;
        p.rd   = v.rd;
        p.wen  = (v.st || v.mis) ? 1'b0 : v.wen;
        p.mis  = v.mis;
        if (!mem || v.mis) p.due = cyc + 1;
        else if (v.st)     p.due = cyc + v.rq + 2;
        else               p.due = cyc + v.rq + 3 + v.rs;
        sb.push_back(p);
        @(posedge clk); #1;
        ex_valid  = 1'b0;
        ex_mem_rd = 1'b0;
        ex_mem_wr = 1'b0;
        if (mem && !v.mis) begin
            for (int i = 0; i <= v.rq; i++) begin
                dmem_req_ready = (i == v.rq);
                if (v.ld) begin
                    dmem_rsp_valid = 1'b1;  // must be ignored while in REQ
                    dmem_rdata     = ~v.rdata;
                end
                @(negedge clk);
                chk("req_valid", 64'(dmem_req_valid), 64'd1);
                chk("req_addr", dmem_addr, v.alu);
                chk("req_we", 64'(dmem_we), 64'(v.st));
                chk("req_wstrb", 64'(dmem_wstrb), 64'(v.strb));
                chk("req_wdata", dmem_wdata, v.wdata);
                chk("req_ex_ready", 64'(ex_ready), 64'd0);
                @(posedge clk); #1;
            end
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b0;
            if (v.ld) begin
                for (int j = 0; j <= v.rs; j++) begin
                    if (j == v.rs) begin
                        dmem_rsp_valid = 1'b1;
                        dmem_rdata     = v.rdata;
                    end
                    @(negedge clk);
                    chk("bus_idle_valid", 64'(dmem_req_valid), 64'd0);
                    chk("bus_idle_wstrb", 64'(dmem_wstrb), 64'd0);
                    @(posedge clk); #1;
                    dmem_rsp_valid = 1'b0;
                end
            end else begin
                @(negedge clk);
                chk("bus_idle_valid", 64'(dmem_req_valid), 64'd0);
                chk("bus_idle_addr", dmem_addr, 64'd0);
                chk("bus_idle_wdata", dmem_wdata, 64'd0);
                @(posedge clk); #1;
            end
        end else if (mem) begin
            @(negedge clk);
            chk("mis_no_req", 64'(dmem_req_valid), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
        chk({tag, "_wb_data"}, wb_data, 64'd0);
        chk({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
        chk({tag, "_wb_wen"}, 64'(wb_wen), 64'd0);
        chk({tag, "_misalign"}, 64'(misalign), 64'd0);
        chk({tag, "_req_valid"}, 64'(dmem_req_valid), 64'd0);
        chk({tag, "_addr"}, dmem_addr, 64'd0);
        chk({tag, "_we"}, 64'(dmem_we), 64'd0);
        chk({tag, "_wdata"}, dmem_wdata, 64'd0);
        chk({tag, "_wstrb"}, 64'(dmem_wstrb), 64'd0);
        chk({tag, "_ex_ready"}, 64'(ex_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] d1;
        d1 = 64'h1234_5678_9ABC_DEF0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("post_reset_ex_ready", 64'(ex_ready), 64'd1);
        @(posedge clk); #1;

        //            alu          sdata  ld st op      rd wen rq rs rdata  exp  mis strb wdata
        vecs.push_back(mk(64'd1, 0, 0, 0, 3'b000, 5, 1, 0, 0, 0, 64'd1, 0, 0, 0));
        vecs.push_back(mk(64'd2, 0, 0, 0, 3'b000, 6, 1, 0, 0, 0, 64'd2, 0, 0, 0));
        vecs.push_back(mk(64'd3, 0, 0, 0, 3'b000, 7, 1, 0, 0, 0, 64'd3, 0, 0, 0));
        vecs.push_back(mk(64'hFFFF_0000_1234_5678, 0, 0, 0, 3'b011, 3, 0, 0, 0, 0,
                          64'hFFFF_0000_1234_5678, 0, 0, 0));
        vecs.push_back(mk(64'h1003, 64'hAB, 0, 1, 3'b000, 9, 0, 2, 0, 0, 0, 0,
                          8'h08, 64'hABAB_ABAB_ABAB_ABAB));
        vecs.push_back(mk(64'h2005, 0, 1, 0, 3'b000, 10, 1, 0, 1, 64'h0000_80FF_0000_0000,
                          64'hFFFF_FFFF_FFFF_FF80, 0, 0, 0));
        vecs.push_back(mk(64'h2005, 0, 1, 0, 3'b100, 11, 1, 0, 1, 64'h0000_80FF_0000_0000,
                          64'h80, 0, 0, 0));
        vecs.push_back(mk(64'h10, 0, 1, 0, 3'b010, 12, 1, 0, 3, 64'h1234_5678_8765_4321,
                          64'hFFFF_FFFF_8765_4321, 0, 0, 0));
        vecs.push_back(mk(64'h0C, 0, 1, 0, 3'b011, 13, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(64'h22, d1, 0, 1, 3'b001, 1, 0, 0, 0, 0, 0, 0,
                          8'h0C, 64'hDEF0_DEF0_DEF0_DEF0));
        vecs.push_back(mk(64'h44, d1, 0, 1, 3'b010, 2, 0, 1, 0, 0, 0, 0,
                          8'hF0, 64'h9ABC_DEF0_9ABC_DEF0));
        vecs.push_back(mk(64'h48, d1, 0, 1, 3'b011, 3, 0, 0, 0, 0, 0, 0, 8'hFF, d1));
        vecs.push_back(mk(64'h50, 64'h1122_3344_5566_7788, 0, 1, 3'b111, 4, 0, 0, 0, 0, 0, 0,
                          8'hFF, 64'h1122_3344_5566_7788));
        vecs.push_back(mk(64'h1000, 64'h1234_56CD, 0, 1, 3'b000, 22, 0, 0, 0, 0, 0, 0,
                          8'h01, 64'hCDCD_CDCD_CDCD_CDCD));
        vecs.push_back(mk(64'h06, 0, 1, 0, 3'b001, 14, 1, 1, 0, 64'h8001_0000_0000_0000,
                          64'hFFFF_FFFF_FFFF_8001, 0, 0, 0));
        vecs.push_back(mk(64'h06, 0, 1, 0, 3'b101, 15, 1, 0, 0, 64'h8001_0000_0000_0000,
                          64'h8001, 0, 0, 0));
        vecs.push_back(mk(64'h0C, 0, 1, 0, 3'b110, 16, 1, 0, 2, 64'hF000_0001_0000_0000,
                          64'hF000_0001, 0, 0, 0));
        vecs.push_back(mk(64'h18, 0, 1, 0, 3'b011, 17, 1, 0, 0, 64'hDEAD_BEEF_CAFE_F00D,
                          64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0));
        vecs.push_back(mk(64'h20, 0, 1, 0, 3'b111, 18, 1, 0, 1, 64'h8000_0000_0000_0001,
                          64'h8000_0000_0000_0001, 0, 0, 0));
        vecs.push_back(mk(64'h101, 64'h55, 0, 1, 3'b001, 19, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(64'h102, 0, 1, 0, 3'b010, 20, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(64'h07, 0, 1, 0, 3'b000, 21, 0, 0, 0, 64'h7F00_0000_0000_0000,
                          64'h7F, 0, 0, 0));

        foreach (vecs[k]) run(vecs[k]);

        // Reset while waiting for a load response; the late response must be dropped.
        ex_valid   = 1'b1;
        ex_alu_res = 64'h40;
        ex_mem_rd  = 1'b1;
        ex_mem_op  = 3'b011;
        ex_rd      = 5'd12;
        ex_reg_wen = 1'b1;
        @(posedge clk); #1;
        ex_valid       = 1'b0;
        ex_mem_rd      = 1'b0;
        dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        @(negedge clk);
        chk("rsp_ex_ready", 64'(ex_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        @(posedge clk); #1;
        rst_n          = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rsp_wb_valid", 64'(wb_valid), 64'd0);
        end
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 64-bit RV64 pipeline, directly downstream of `ex_stage`. Accepts one instruction at a time from EX: the ALU result (a data or an effective address), store data, a memory op code and a destination register. Drives a valid/ready data-memory bus with byte-lane alignment and store strobes, sign/zero-extends load data, and presents a registered one-cycle writeback packet to WB. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- none. Address and data widths are fixed at 64.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX presents an instruction.
- `ex_ready` out 1: stage can accept. Equals state==IDLE.
- `ex_alu_res` in 64: ALU result. It is the effective address for loads and stores.
- `ex_store_data` in 64: rs2 value for stores.
- `ex_mem_rd` in 1: instruction is a load.
- `ex_mem_wr` in 1: instruction is a store. `ex_mem_rd` and `ex_mem_wr` are never both 1.
- `ex_mem_op` in 3: funct3 encoding.
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- `ex_rd` in 5: destination register.
- `ex_reg_wen` in 1: instruction writes rd.
- `dmem_req_valid` out 1: bus request.
- `dmem_req_ready` in 1: memory accepts the request.
- `dmem_addr` out 64: byte address, unmodified.
- `dmem_we` out 1: 1 = store.
- `dmem_wdata` out 64: store data shifted into its byte lane.
- `dmem_wstrb` out 8: byte-enable strobes.
- `dmem_rsp_valid` in 1: load response valid.
- `dmem_rdata` in 64: aligned 64-bit doubleword containing the address.
- `wb_valid` out 1: writeback packet valid. High for exactly one cycle per instruction.
- `wb_data` out 64: result written back.
- `wb_rd` out 5: destination register.
- `wb_wen` out 1: register write enable.
- `misalign` out 1: pulses together with `wb_valid` when the access is misaligned.

## Operation
- State machine states: IDLE, REQ, RSP.
- IDLE, handshake `ex_valid && ex_ready`: capture all `ex_*` inputs into internal registers.
  - Non-memory op: on the next edge, `wb_valid`=1, `wb_data`=alu_res, `wb_wen`=ex_reg_wen. Stay in IDLE.
  - Memory op, misaligned: on the next edge, `wb_valid`=1, `misalign`=1, `wb_wen`=0, `wb_data`=0. No bus request is issued. Stay in IDLE.
    - Misaligned means: H and addr[0]≠0; W and addr[1:0]≠0; D and addr[2:0]≠0.
  - Memory op, aligned: go to REQ.
- REQ: `dmem_req_valid`=1. All `dmem_*` outputs are held stable until `dmem_req_ready`=1.
  - Store accepted: `wb_valid`=1 with `wb_wen`=0. Go to IDLE.
  - Load accepted: go to RSP.
- RSP: wait for `dmem_rsp_valid`.
  - On the response, extract the lane at offset `addr[2:0]`, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU/LD).
  - `wb_valid`=1, `wb_data`=extended value, `wb_wen`=ex_reg_wen. Go to IDLE.
- Store lane formatting, with off=addr[2:0]:
  - SB: wstrb = 1<<off; wdata = {8{byte}}.
  - SH: wstrb = 2'b11<<off; wdata = {4{half}}.
  - SW: wstrb = 4'hF<<off; wdata = {2{word}}.
  - SD: wstrb = 8'hFF; wdata = data.
- Load requests drive `dmem_we`=0, `dmem_wstrb`=0, `dmem_wdata`=0.
- Idle bus: when `dmem_req_valid`=0, all other `dmem_*` outputs are 0.
- `wb_rd` always equals the captured rd when `wb_valid`=1.
- `dmem_rsp_valid` received in IDLE or REQ is ignored.
- Undefined `ex_mem_op` values for loads (111) and stores (1xx) are treated as LD and SD respectively.

## Timing
- Reset, asynchronous: state=IDLE and every registered output is 0.
  - This covers `wb_valid`, `wb_data`, `wb_rd`, `wb_wen`, `misalign` and all `dmem_*` outputs.
  - `ex_ready`=1 immediately after reset deasserts.
- Reset asserted mid-transaction abandons the transaction. Any later response is ignored.
- Non-memory op accepted at edge N: `wb_valid` at N+1. Throughput is one instruction per cycle.
- Store accepted at N: `dmem_req_valid` high from N+1. If ready at N+1, `wb_valid` at N+2.
- Load: request from N+1. Response sampled at edge M: `wb_valid` is high for the cycle after M.
- `ex_ready` is 1 in the same cycle `wb_valid` is 1, so back-to-back acceptance is allowed.
- `dmem_rsp_valid` and `dmem_req_ready` may both be 1 in the same cycle. Only the one relevant to the current state is honoured.
- WB has no backpressure: `wb_*` are valid only while `wb_valid`=1.

## Test plan
- Reset check: hold `rst_n`=0, then release.
  - Expect all outputs 0 and `ex_ready`=1.
  - Assert `rst_n` while in RSP: state returns to IDLE and a late `dmem_rsp_valid` produces no `wb_valid`.
- Three back-to-back ALU ops with alu_res = 1, 2, 3 and rd = 5, 6, 7.
  - Expect `wb_valid` on three consecutive cycles with matching data and rd.
- SB: addr=0x1003, data=0xAB, `dmem_req_ready` delayed 2 cycles.
  - Expect `dmem_wstrb`=0x08, `dmem_wdata`=0xABAB…AB.
  - `dmem_*` outputs stay stable throughout the stall.
  - `wb_valid` with `wb_wen`=0.
- LB vs LBU: addr=0x2005, rdata=0x0000_80FF_0000_0000.
  - LB gives `wb_data`=0xFFFF_FFFF_FFFF_FF80.
  - LBU gives `wb_data`=0x80.
- LW: addr=0x10, rdata=0x1234_5678_8765_4321, response after 3 cycles.
  - Expect `wb_data`=0xFFFF_FFFF_8765_4321 the cycle after the response.
- LD with addr=0x0C (misaligned).
  - Expect no `dmem_req_valid`.
  - `wb_valid`=1, `misalign`=1 and `wb_wen`=0, one cycle after acceptance.
